// File: rtl/wm8731_key_vol_ctrl.sv
// rtl/wm8731_key_vol_ctrl.sv - key-driven headphone volume/mute writer for the WM8731
//
// Turns debounced key pulses into volume/mute state and issues one register
// 0x02 write at a time to the codec configuration engine (req/ack).
// Presses arriving while a write is outstanding are merged into a single
// follow-up write that carries the latest state.
//
// Ports:
//   clk_in       system clock
//   rst_n        synchronous active-low reset
//   key_pulse    [0] volume up, [1] volume down, [2] mute toggle (1-cycle pulses)
//   cfg_req      write request, held until cfg_ack
//   cfg_word     {reg_addr[6:0], reg_data[8:0]}, stable while cfg_req=1
//   cfg_ack      write-complete pulse, honoured only while cfg_req=1
//   vol_level    current volume code
//   muted        current mute state
//   busy         high while a write is outstanding
//   err_timeout  one-cycle pulse on ack timeout
//
// Optional feature: define WM8731_KEY_VOL_CTRL_TIMEOUT_EN to abandon a write
// after ACK_TIMEOUT request cycles without an ack and retry it.
module wm8731_key_vol_ctrl #(
  parameter logic [6:0]  VOL_INIT    = 7'h79,
  parameter logic [6:0]  VOL_MIN     = 7'h30,
  parameter logic [6:0]  VOL_MAX     = 7'h7F,
  parameter logic [6:0]  VOL_STEP    = 7'd4,
  parameter logic [19:0] ACK_TIMEOUT = 20'd1_000_000
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [2:0]  key_pulse,
  output logic        cfg_req,
  output logic [15:0] cfg_word,
  input  logic        cfg_ack,
  output logic [6:0]  vol_level,
  output logic        muted,
  output logic        busy,
  output logic        err_timeout
);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t     state_q, state_d;
  logic       dirty_q, dirty_d;
  logic       ev_mute, ev_up, ev_down, ev_any;
  logic [7:0] vol_sum, vol_dif;
  logic [6:0] vol_d;
  logic       muted_d;
  logic [6:0] eff_vol;
  logic       load_word;
  logic       ack_expired;
  logic       timeout_hit;

  // Mute has priority; up+down together cancel out and are not an event.
  always_comb begin
    ev_mute = key_pulse[2];
    ev_up   = !key_pulse[2] && key_pulse[0] && !key_pulse[1];
    ev_down = !key_pulse[2] && key_pulse[1] && !key_pulse[0];
    ev_any  = ev_mute || ev_up || ev_down;

    // 8-bit arithmetic so overflow past 0x7F and underflow below 0 are visible
    vol_sum = {1'b0, vol_level} + {1'b0, VOL_STEP};
    vol_dif = {1'b0, vol_level} - {1'b0, VOL_STEP};

    vol_d   = vol_level;
    muted_d = muted;
    if (ev_mute) begin
      muted_d = !muted;
    end else if (ev_up) begin
      vol_d = (vol_sum > {1'b0, VOL_MAX}) ? VOL_MAX : vol_sum[6:0];
    end else if (ev_down) begin
      vol_d = (vol_dif[7] || (vol_dif < {1'b0, VOL_MIN})) ? VOL_MIN : vol_dif[6:0];
    end
  end

  assign eff_vol = muted ? 7'h00 : vol_level;

  always_comb begin
    state_d     = state_q;
    load_word   = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dirty_q) begin
          load_word = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        // an ack on the timeout edge wins, so no error in that case
        if (cfg_ack) begin
          state_d = S_IDLE;
        end else if (ack_expired) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // a key event on the snapshot edge keeps dirty set for another write
    dirty_d = ev_any || timeout_hit || (dirty_q && !load_word);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dirty_q   <= 1'b1;
      vol_level <= VOL_INIT;
      muted     <= 1'b0;
      cfg_word  <= 16'h0000;
    end else begin
      state_q   <= state_d;
      dirty_q   <= dirty_d;
      vol_level <= vol_d;
      muted     <= muted_d;
      // register 0x02, LRHPBOTH=1, LZCEN=0
      if (load_word) cfg_word <= {7'h02, 1'b1, 1'b0, eff_vol};
    end
  end

  assign cfg_req = (state_q == S_REQ);
  assign busy    = (state_q == S_REQ);

`ifdef WM8731_KEY_VOL_CTRL_TIMEOUT_EN
  logic [19:0] ack_cnt;

  // held at zero outside REQ, so it reads zero on the first REQ cycle
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      ack_cnt     <= 20'd0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= timeout_hit;
      if (state_q != S_REQ) ack_cnt <= 20'd0;
      else                  ack_cnt <= ack_cnt + 20'd1;
    end
  end

  assign ack_expired = (ack_cnt == ACK_TIMEOUT - 20'd1);
`else
  logic unused_ack_timeout;

  assign unused_ack_timeout = ^ACK_TIMEOUT;
  assign ack_expired        = 1'b0;
  assign err_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_wm8731_key_vol_ctrl.sv
// tb/tb_wm8731_key_vol_ctrl.sv - self-checking bench for wm8731_key_vol_ctrl
module tb_wm8731_key_vol_ctrl;

  localparam int TO = 16;
`ifdef WM8731_KEY_VOL_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic [2:0]  key_pulse;
  logic        cfg_req;
  logic [15:0] cfg_word;
  logic        cfg_ack;
  logic [6:0]  vol_level;
  logic        muted;
  logic        busy;
  logic        err_timeout;

  wm8731_key_vol_ctrl #(.ACK_TIMEOUT(20'(TO))) dut (
    .clk_in(clk_in), .rst_n(rst_n), .key_pulse(key_pulse),
    .cfg_req(cfg_req), .cfg_word(cfg_word), .cfg_ack(cfg_ack),
    .vol_level(vol_level), .muted(muted), .busy(busy),
    .err_timeout(err_timeout)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_vol, m_word, m_tcnt;
  bit m_muted, m_pend, m_req, m_err;

  always @(posedge clk_in) begin
    if (!rst_n) begin
      m_vol = 'h79; m_muted = 0; m_pend = 1; m_req = 0;
      m_word = 0; m_err = 0; m_tcnt = 0;
    end else begin
      m_err = 0;
      // the write engine acts on the state as it stood before this edge's key
      if (m_req) begin
        if (cfg_ack) m_req = 0;
        else if (TO_EN && m_tcnt == TO - 1) begin
          m_req = 0; m_err = 1; m_pend = 1;
        end else m_tcnt++;
      end else if (m_pend) begin
        m_req = 1; m_pend = 0; m_tcnt = 0;
        m_word = 'h0500 + (m_muted ? 0 : m_vol);
      end
      if (key_pulse[2]) begin
        m_muted = !m_muted; m_pend = 1;
      end else if (key_pulse[0] != key_pulse[1]) begin
        if (key_pulse[0]) m_vol = (m_vol + 4 > 'h7F) ? 'h7F : m_vol + 4;
        else              m_vol = (m_vol - 4 < 'h30) ? 'h30 : m_vol - 4;
        m_pend = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit chk_en = 0;
  int busy_cnt = 0;

  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("cfg_req", cfg_req, m_req);
      chk("busy", busy, m_req);
      chk("cfg_word", cfg_word, m_word);
      chk("vol_level", vol_level, m_vol);
      chk("muted", muted, m_muted);
      chk("err_timeout", err_timeout, m_err);
      if (busy) busy_cnt++;
    end
  end

  // ---------------- ack responder ----------------
  bit ack_en = 1;
  bit stray_ack = 0;
  int ack_lat = 3;
  int req_cycles = 0;
  logic [15:0] wlog[$];

  always @(negedge clk_in) begin
    if (cfg_req && ack_en) begin
      req_cycles++;
      if (req_cycles == ack_lat) begin
        cfg_ack = 1'b1;
        wlog.push_back(cfg_word);
      end else cfg_ack = stray_ack;
    end else begin
      req_cycles = 0;
      cfg_ack = stray_ack;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic press(input logic [2:0] k);
    key_pulse = k;
    tick(1);
    key_pulse = 3'b000;
  endtask

  task automatic do_reset(input int drain);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    tick(drain);
  endtask

  bit tr_req[20];
  bit tr_err[20];
  int n, run, errs;

  initial begin
    rst_n = 1'b0;
    key_pulse = 3'b000;
    cfg_ack = 1'b0;
    tick(2);
    chk_en = 1;

    // reset values
    chk("rst cfg_req", cfg_req, 0);
    chk("rst cfg_word", cfg_word, 'h0000);
    chk("rst vol", vol_level, 'h79);
    chk("rst muted", muted, 0);
    chk("rst busy", busy, 0);
    chk("rst err", err_timeout, 0);

    // release, ack after 11 request cycles
    ack_lat = 11;
    busy_cnt = 0;
    rst_n = 1'b1;
    tick(1);
    chk("first req", cfg_req, 1);
    chk("first word", cfg_word, 'h0579);
    tick(30);
    chk("busy cycles", busy_cnt, 11);
    chk("init writes", wlog.size(), 1);
    if (wlog.size() >= 1) chk("init word", wlog[0], 'h0579);
    chk("idle after init", cfg_req, 0);

    // up to the ceiling
    ack_lat = 3;
    wlog.delete();
    press(3'b001); tick(10);
    press(3'b001); tick(10);
    press(3'b001); tick(10);
    chk("up writes", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("up w0", wlog[0], 'h057D);
      chk("up w1", wlog[1], 'h057F);
      chk("up w2", wlog[2], 'h057F);
    end
    chk("up vol", vol_level, 'h7F);

    // mute, down while muted, unmute
    do_reset(12);
    wlog.delete();
    press(3'b100); tick(10);
    press(3'b010); tick(10);
    chk("mute writes", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("mute w0", wlog[0], 'h0500);
      chk("mute w1", wlog[1], 'h0500);
    end
    chk("muted vol", vol_level, 'h75);
    press(3'b100); tick(10);
    chk("unmute writes", wlog.size(), 3);
    if (wlog.size() == 3) chk("unmute w", wlog[2], 'h0575);

    // three downs coalesced behind the outstanding reset write
    ack_en = 0;
    do_reset(0);
    press(3'b010); tick(1);
    press(3'b010); tick(1);
    press(3'b010); tick(1);
    chk("held req", cfg_req, 1);
    chk("held word", cfg_word, 'h0579);
    chk("coalesce vol", vol_level, 'h6D);
    wlog.delete();
    ack_en = 1;
    tick(20);
    chk("coalesce writes", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("coalesce w0", wlog[0], 'h0579);
      chk("coalesce w1", wlog[1], 'h056D);
    end

    // simultaneous keys
    do_reset(12);
    wlog.delete();
    press(3'b011); tick(10);
    chk("updown writes", wlog.size(), 0);
    chk("updown vol", vol_level, 'h79);
    press(3'b101); tick(10);
    chk("upmute writes", wlog.size(), 1);
    if (wlog.size() == 1) chk("upmute w", wlog[0], 'h0500);
    chk("upmute vol", vol_level, 'h79);

    // stray ack while idle
    stray_ack = 1; tick(1); stray_ack = 0; tick(3);
    chk("stray req", cfg_req, 0);
    chk("stray writes", wlog.size(), 1);

    // reset in the middle of a write
    ack_en = 0;
    press(3'b001); tick(2);
    chk("mid req", cfg_req, 1);
    rst_n = 1'b0; tick(1);
    chk("mid rst req", cfg_req, 0);
    chk("mid rst vol", vol_level, 'h79);
    wlog.delete();
    ack_en = 1;
    rst_n = 1'b1;
    tick(20);
    chk("mid rst writes", wlog.size(), 1);
    if (wlog.size() == 1) chk("mid rst w", wlog[0], 'h0579);

    // down to the floor and one saturated step below it
    for (int i = 0; i < 20; i++) begin
      press(3'b010); tick(5);
    end
    tick(10);
    chk("floor vol", vol_level, 'h30);
    chk("floor last w", wlog[$], 'h0530);
    n = wlog.size();
    press(3'b010); tick(10);
    chk("floor sat writes", wlog.size(), n + 1);
    chk("floor sat w", wlog[$], 'h0530);

`ifdef WM8731_KEY_VOL_CTRL_TIMEOUT_EN
    // no ack at all: drop after TO request cycles, one error, retry next cycle
    ack_en = 0;
    do_reset(0);
    for (int k = 0; k < 20; k++) begin
      tr_req[k] = cfg_req;
      tr_err[k] = err_timeout;
      tick(1);
    end
    run = 0;
    while (run < 20 && tr_req[run]) run++;
    errs = 0;
    for (int k = 0; k < 20; k++) errs += int'(tr_err[k]);
    chk("to high run", run, TO);
    chk("to err at drop", tr_err[TO], 1);
    chk("to err count", errs, 1);
    chk("to retry", tr_req[TO + 1], 1);
    ack_en = 1;
    tick(20);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
